// File: rtl/cp0_reg_if.sv
// MTC0 write port and MFC0 read port of the CP0 register file.
// The master side (WB stage / pipeline) drives the write and read address; the slave returns read data.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  modport master (output we_i, output waddr_i, output data_i, output raddr_i, input data_o);
  modport slave  (input we_i, input waddr_i, input data_i, input raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: MTC0/MFC0 with WB forwarding, exception/ERET commit, Count/Compare timer.
// Optional timer is built only when CP0_TIMER_EN is defined.
module cp0_reg #(
  parameter logic [31:0] PRID         = 32'h004c_0102,
  parameter logic [31:0] STATUS_RESET = 32'h1000_0000,
  parameter logic [31:0] CONFIG_RESET = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  cp0_reg_if.slave    bus,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  // Software-writable Cause bits: IV, WP, IP[1:0]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  logic        exc_take;
  logic        exc_eret;
  logic [4:0]  exc_code;

  always_comb begin
    exc_take = 1'b1;
    exc_eret = 1'b0;
    exc_code = 5'h00;
    case (excepttype_i)
      32'h0000_0001: exc_code = 5'h00;
      32'h0000_0008: exc_code = 5'h08;
      32'h0000_000a: exc_code = 5'h0a;
      32'h0000_000d: exc_code = 5'h0d;
      32'h0000_000c: exc_code = 5'h0c;
      32'h0000_000e: begin exc_take = 1'b0; exc_eret = 1'b1; end
      default:       exc_take = 1'b0;
    endcase
  end

  // MTC0 is applied first; the exception commit afterwards overrides only the fields it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
    end else begin
      cause_q[15:10] <= int_i;
      if (bus.we_i) begin
        case (bus.waddr_i)
          REG_STATUS: status_q <= bus.data_i;
          REG_CAUSE: begin
            cause_q[9:8]   <= bus.data_i[9:8];
            cause_q[23:22] <= bus.data_i[23:22];
          end
          REG_EPC:    epc_q <= bus.data_i;
          default: ;
        endcase
      end
      if (exc_take) begin
        if (!status_q[1]) begin
          epc_q       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause_q[31] <= is_in_delayslot_i;
        end
        status_q[1]  <= 1'b1;
        cause_q[6:2] <= exc_code;
      end else if (exc_eret) begin
        status_q[1] <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;

  // A Count load replaces the increment; a Compare load clears the interrupt even on a same-cycle match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      timer_int_q <= 1'b0;
    end else begin
      count_q <= count_q + 32'd1;
      if ((compare_q != 32'h0) && (count_q == compare_q))
        timer_int_q <= 1'b1;
      if (bus.we_i) begin
        case (bus.waddr_i)
          REG_COUNT:   count_q <= bus.data_i;
          REG_COMPARE: begin
            compare_q   <= bus.data_i;
            timer_int_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;
`else
  assign count_o     = 32'h0;
  assign compare_o   = 32'h0;
  assign timer_int_o = 1'b0;
`endif

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_RESET;
  assign prid_o   = PRID;

  logic [31:0] rd_sel;

  always_comb begin
    rd_sel = 32'h0;
    case (bus.raddr_i)
      REG_COUNT:   rd_sel = count_o;
      REG_COMPARE: rd_sel = compare_o;
      REG_STATUS:  rd_sel = status_q;
      REG_CAUSE:   rd_sel = cause_q;
      REG_EPC:     rd_sel = epc_q;
      REG_PRID:    rd_sel = PRID;
      REG_CONFIG:  rd_sel = CONFIG_RESET;
      default:     rd_sel = 32'h0;
    endcase
  end

  // Same-cycle WB forwarding; a forwarded Cause shows only the writable bits merged in.
  always_comb begin
    if (rst)
      bus.data_o = 32'h0;
    else if (bus.we_i && (bus.waddr_i == bus.raddr_i))
      bus.data_o = (bus.raddr_i == REG_CAUSE)
                 ? ((cause_q & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK))
                 : bus.data_i;
    else
      bus.data_o = rd_sel;
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: a register-level reference model checked every cycle,
// plus hand-computed literal checks of the scenarios the block is known for.
module tb_cp0_reg;

  localparam logic [31:0] PRID_V   = 32'h004c_0102;
  localparam logic [31:0] STAT_RST = 32'h1000_0000;
  localparam logic [31:0] CONF_RST = 32'h0000_8000;
  localparam logic [31:0] WMASK    = 32'h00C0_0300;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  cp0_reg_if bus ();

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus.slave),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = STAT_RST; m_cause = 0; m_epc = 0; m_tint = 0;
    end else begin : model_step
      logic [31:0] o_count, o_compare, o_status;
      int code;
      o_count = m_count; o_compare = m_compare; o_status = m_status;
      m_cause[15:10] = int_i;
      if (TIMER) begin
        m_count = o_count + 1;
        if (o_compare != 0 && o_count == o_compare) m_tint = 1;
      end
      if (bus.we_i) begin
        if (TIMER && bus.waddr_i == 9)  m_count = bus.data_i;
        if (TIMER && bus.waddr_i == 11) begin m_compare = bus.data_i; m_tint = 0; end
        if (bus.waddr_i == 12) m_status = bus.data_i;
        if (bus.waddr_i == 13) m_cause = (m_cause & ~WMASK) | (bus.data_i & WMASK);
        if (bus.waddr_i == 14) m_epc = bus.data_i;
      end
      code = -1;
      if (excepttype_i == 32'h1) code = 0;
      if (excepttype_i == 32'h8 || excepttype_i == 32'ha || excepttype_i == 32'hd || excepttype_i == 32'hc)
        code = int'(excepttype_i);
      if (code >= 0) begin
        if (o_status[1] == 1'b0) begin
          m_epc = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
          m_cause[31] = is_in_delayslot_i;
        end
        m_status[1] = 1'b1;
        m_cause[6:2] = code[4:0];
      end else if (excepttype_i == 32'he) begin
        m_status[1] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] m_read();
    logic [31:0] regs [0:31];
    for (int i = 0; i < 32; i++) regs[i] = 0;
    regs[9] = m_count; regs[11] = m_compare; regs[12] = m_status; regs[13] = m_cause;
    regs[14] = m_epc; regs[15] = PRID_V; regs[16] = CONF_RST;
    if (rst) return 0;
    if (bus.we_i && bus.waddr_i == bus.raddr_i)
      return (bus.raddr_i == 13) ? ((m_cause & ~WMASK) | (bus.data_i & WMASK)) : bus.data_i;
    return regs[bus.raddr_i];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("count",   count_o,   m_count);
    chk("compare", compare_o, m_compare);
    chk("status",  status_o,  m_status);
    chk("cause",   cause_o,   m_cause);
    chk("epc",     epc_o,     m_epc);
    chk("config",  config_o,  CONF_RST);
    chk("prid",    prid_o,    PRID_V);
    chk("timer",   {31'b0, timer_int_o}, {31'b0, m_tint});
    chk("data_o",  bus.data_o, m_read());
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0;
    excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1; bus.waddr_i = a; bus.data_i = d;
    cyc();
    bus.we_i = 0;
  endtask

  task automatic except(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    cyc();
    excepttype_i = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; int_i = 0; bus.raddr_i = 12; idle();
    cyc(2);
    chk("rst_count",  count_o,  32'h0);
    chk("rst_status", status_o, 32'h1000_0000);
    chk("rst_config", config_o, 32'h0000_8000);
    chk("rst_prid",   prid_o,   32'h004c_0102);
    chk("rst_data_o", bus.data_o, 32'h0);
    rst = 0;
    cyc(3);
    chk("count_run", count_o, TIMER ? 32'd3 : 32'd0);

    // Reset mid-operation: a pending EPC write must not survive
    bus.we_i = 1; bus.waddr_i = 14; bus.data_i = 32'h1234_5678; rst = 1;
    cyc();
    idle(); rst = 0;
    chk("mid_rst_epc",   epc_o,   32'h0);
    chk("mid_rst_count", count_o, 32'h0);

    // Timer: Compare=5, Count=0
    mtc0(11, 32'd5);
    mtc0(9, 32'd0);
    cyc(5);
    chk("timer_before", {31'b0, timer_int_o}, 32'h0);
    cyc();
    chk("timer_fire", {31'b0, timer_int_o}, TIMER ? 32'h1 : 32'h0);
    cyc(3);
    chk("timer_sticky", {31'b0, timer_int_o}, TIMER ? 32'h1 : 32'h0);
    mtc0(11, 32'd9);
    chk("timer_clear", {31'b0, timer_int_o}, 32'h0);

    // WB forwarding on Status
    bus.raddr_i = 12; bus.we_i = 1; bus.waddr_i = 12; bus.data_i = 32'h1000_0001;
    #1 chk("fwd_status", bus.data_o, 32'h1000_0001);
    cyc(); bus.we_i = 0;
    chk("status_written", status_o, 32'h1000_0001);

    // Syscall in delay slot, then Ov with EXL=1, then ERET
    except(32'h8, 32'h100, 1'b1);
    chk("sys_epc",  epc_o, 32'hFC);
    chk("sys_bd",   {31'b0, cause_o[31]}, 32'h1);
    chk("sys_code", {27'b0, cause_o[6:2]}, 32'h08);
    chk("sys_exl",  {31'b0, status_o[1]}, 32'h1);
    except(32'hc, 32'h200, 1'b0);
    chk("ov_epc",  epc_o, 32'hFC);
    chk("ov_code", {27'b0, cause_o[6:2]}, 32'h0c);
    except(32'he, 32'h0, 1'b0);
    chk("eret_exl", {31'b0, status_o[1]}, 32'h0);
    except(32'h5, 32'h300, 1'b0);
    chk("other_code_epc", epc_o, 32'hFC);

    // Cause write mask with interrupts, from a clean state
    rst = 1; cyc(); rst = 0;
    int_i = 6'h3F; bus.raddr_i = 13;
    bus.we_i = 1; bus.waddr_i = 13; bus.data_i = 32'hFFFF_FFFF;
    #1 chk("fwd_cause", bus.data_o, 32'h00C0_0300);
    cyc(); bus.we_i = 0;
    chk("cause_mask", cause_o, 32'h00C0_FF00);
    int_i = 6'h05;
    cyc();
    chk("cause_ip", {26'b0, cause_o[15:10]}, 32'h05);

    // Count wrap
    mtc0(9, 32'hFFFF_FFFF);
    chk("count_max", count_o, TIMER ? 32'hFFFF_FFFF : 32'h0);
    cyc();
    chk("count_wrap", count_o, 32'h0);

    // MTC0 Status together with RI: exception owns EXL and EPC
    bus.we_i = 1; bus.waddr_i = 12; bus.data_i = 32'h1000_0000;
    except(32'ha, 32'h400, 1'b0);
    bus.we_i = 0;
    chk("simul_status", status_o, 32'h1000_0002);
    chk("simul_epc",    epc_o,    32'h400);

    // MTC0 EPC together with an exception while EXL=1: MTC0 keeps EPC
    bus.we_i = 1; bus.waddr_i = 14; bus.data_i = 32'hABCD_0000;
    except(32'hd, 32'h500, 1'b1);
    bus.we_i = 0;
    chk("exl1_epc",  epc_o, 32'hABCD_0000);
    chk("exl1_code", {27'b0, cause_o[6:2]}, 32'h0d);

    // Read-only / unmapped writes and a full read sweep
    mtc0(15, 32'hDEAD_BEEF);
    mtc0(16, 32'hDEAD_BEEF);
    mtc0(3,  32'hDEAD_BEEF);
    for (int i = 0; i < 32; i++) begin
      bus.raddr_i = 5'(i);
      cyc();
    end
    chk("prid_ro",   prid_o,   32'h004c_0102);
    chk("config_ro", config_o, 32'h0000_8000);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
